// File: rtl/apb_timer_multi.sv
// rtl/apb_timer_multi.sv - multi-channel APB timer with prescaler, compare, one-shot and W1C status
module apb_timer_multi #(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int N_TIMERS       = 4,
  parameter int TIMER_WIDTH    = 32
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR,
  input  logic [31:0]               PWDATA,
  input  logic                      PWRITE,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  output logic [31:0]               PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR,
  output logic [N_TIMERS-1:0]       irq_o
);

  logic [3:0] ch_sel;
  logic [1:0] reg_sel;
  logic       ch_valid;
  logic       access;
  logic       wr_en;
  logic       rd_en;
  logic [N_TIMERS-1:0][31:0] rd_data;
  logic       unused_bits;

  assign ch_sel   = PADDR[7:4];
  assign reg_sel  = PADDR[3:2];
  assign ch_valid = ({1'b0, ch_sel} < 5'(N_TIMERS));
  assign access   = PSEL & PENABLE;
  assign wr_en    = access & PWRITE & ch_valid;
  assign rd_en    = access & ~PWRITE & ch_valid;
  assign PREADY   = 1'b1;
  assign PSLVERR  = access & ~ch_valid;
  assign unused_bits = ^{PADDR, PWDATA};

  for (genvar c = 0; c < N_TIMERS; c++) begin : g_ch
    logic [TIMER_WIDTH-1:0] count_q, count_d, cmp_q, cmp_d;
    logic [7:0] presc_q, presc_d, presc_cnt_q, presc_cnt_d;
    logic en_q, en_d, oneshot_q, oneshot_d, ovf_ie_q, ovf_ie_d, cmp_ie_q, cmp_ie_d;
    logic ovf_q, ovf_d, cmpf_q, cmpf_d;
    logic wr_sel, tick, cmp_evt, ovf_evt;

    assign wr_sel  = wr_en && (ch_sel == 4'(c));
    assign tick    = en_q && (presc_cnt_q == presc_q);
    assign cmp_evt = tick && (cmp_q != '0) && (count_q == cmp_q);
    assign ovf_evt = tick && (count_q == '1);

    always_comb begin
      count_d     = count_q;
      cmp_d       = cmp_q;
      presc_d     = presc_q;
      presc_cnt_d = presc_cnt_q;
      en_d        = en_q;
      oneshot_d   = oneshot_q;
      ovf_ie_d    = ovf_ie_q;
      cmp_ie_d    = cmp_ie_q;
      ovf_d       = ovf_q;
      cmpf_d      = cmpf_q;

      if (!en_q || tick) presc_cnt_d = 8'd0;
      else               presc_cnt_d = presc_cnt_q + 8'd1;

      if (tick) begin
        if (cmp_evt || ovf_evt) count_d = '0;
        else                    count_d = count_q + TIMER_WIDTH'(1);
      end
      if (cmp_evt) begin
        cmpf_d = 1'b1;
        if (oneshot_q) en_d = 1'b0;
      end
      if (ovf_evt) ovf_d = 1'b1;

      // Bus writes override the tick update; W1C still loses to a same-cycle set.
      if (wr_sel) begin
        case (reg_sel)
          2'd0: count_d = PWDATA[TIMER_WIDTH-1:0];
          2'd1: begin
            en_d        = PWDATA[0];
            oneshot_d   = PWDATA[1];
            ovf_ie_d    = PWDATA[2];
            cmp_ie_d    = PWDATA[3];
            presc_d     = PWDATA[15:8];
            presc_cnt_d = 8'd0;
          end
          2'd2: begin
            cmp_d       = PWDATA[TIMER_WIDTH-1:0];
            count_d     = '0;
            presc_cnt_d = 8'd0;
          end
          default: begin
            ovf_d  = (ovf_q & ~PWDATA[0]) | ovf_evt;
            cmpf_d = (cmpf_q & ~PWDATA[1]) | cmp_evt;
          end
        endcase
      end
    end

    always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
        count_q     <= '0;
        cmp_q       <= '0;
        presc_q     <= 8'd0;
        presc_cnt_q <= 8'd0;
        en_q        <= 1'b0;
        oneshot_q   <= 1'b0;
        ovf_ie_q    <= 1'b0;
        cmp_ie_q    <= 1'b0;
        ovf_q       <= 1'b0;
        cmpf_q      <= 1'b0;
      end else begin
        count_q     <= count_d;
        cmp_q       <= cmp_d;
        presc_q     <= presc_d;
        presc_cnt_q <= presc_cnt_d;
        en_q        <= en_d;
        oneshot_q   <= oneshot_d;
        ovf_ie_q    <= ovf_ie_d;
        cmp_ie_q    <= cmp_ie_d;
        ovf_q       <= ovf_d;
        cmpf_q      <= cmpf_d;
      end
    end

    assign irq_o[c] = (ovf_q & ovf_ie_q) | (cmpf_q & cmp_ie_q);

    always_comb begin
      case (reg_sel)
        2'd0:    rd_data[c] = 32'(count_q);
        2'd1:    rd_data[c] = {16'd0, presc_q, 4'd0, cmp_ie_q, ovf_ie_q, oneshot_q, en_q};
        2'd2:    rd_data[c] = 32'(cmp_q);
        default: rd_data[c] = {30'd0, cmpf_q, ovf_q};
      endcase
    end
  end

  always_comb begin
    PRDATA = 32'd0;
    if (rd_en) begin
      for (int c = 0; c < N_TIMERS; c++) begin
        if (ch_sel == 4'(c)) PRDATA = rd_data[c];
      end
    end
  end

endmodule

// File: tb/tb_apb_timer_multi.sv
// tb/tb_apb_timer_multi.sv - scoreboard bench for apb_timer_multi
module tb_apb_timer_multi;
  localparam int N = 4;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic [11:0] PADDR = 12'd0;
  logic [31:0] PWDATA = 32'd0;
  logic        PWRITE = 1'b0;
  logic        PSEL = 1'b0;
  logic        PENABLE = 1'b0;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;
  logic [N-1:0] irq_o;

  apb_timer_multi #(.APB_ADDR_WIDTH(12), .N_TIMERS(N), .TIMER_WIDTH(32)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE),
    .PSEL(PSEL), .PENABLE(PENABLE), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .irq_o(irq_o)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    logic [31:0] data;
    logic        err;
    string       name;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  logic irq_req = 1'b0;
  logic done_req = 1'b0;

  always @(negedge HCLK) begin
    if (PSEL && PENABLE && !PWRITE) begin
      if (q.size() == 0) begin
        errors <= errors + 1;
        $display("FAIL unexpected_read: got data=0x%08h with empty scoreboard", PRDATA);
      end else begin
        checks <= checks + 1;
        if (PRDATA !== q[0].data || PSLVERR !== q[0].err || PREADY !== 1'b1) begin
          errors <= errors + 1;
          $display("FAIL %s: got data=0x%08h err=%0b ready=%0b, expected data=0x%08h err=%0b ready=1",
                   q[0].name, PRDATA, PSLVERR, PREADY, q[0].data, q[0].err);
        end
        q.pop_front();
      end
    end else if (irq_req) begin
      if (q.size() == 0) begin
        errors <= errors + 1;
        $display("FAIL unexpected_irq_check: irq=0x%0h with empty scoreboard", irq_o);
      end else begin
        checks <= checks + 1;
        if (32'(irq_o) !== q[0].data) begin
          errors <= errors + 1;
          $display("FAIL %s: got irq=0x%0h, expected irq=0x%0h", q[0].name, irq_o, q[0].data);
        end
        q.pop_front();
      end
    end else if (done_req) begin
      checks <= checks + 1;
      if (q.size() != 0) begin
        errors <= errors + 1;
        $display("FAIL scoreboard_drain: got %0d pending, expected 0", q.size());
      end
    end
  end

  function automatic logic [11:0] addr(input int ch, input int r);
    return 12'((ch << 4) | (r << 2));
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge HCLK);
  endtask

  task automatic apb_wr(input int ch, input int r, input logic [31:0] d);
    @(posedge HCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = addr(ch, r); PWDATA = d;
    @(posedge HCLK); #1;
    PENABLE = 1'b1;
    @(posedge HCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  // Sampled value reflects state after the second edge following the call.
  task automatic apb_rd(input int ch, input int r, input logic [31:0] exp, input logic err, input string name);
    exp_t e;
    @(posedge HCLK); #1;
    e.data = exp; e.err = err; e.name = name;
    q.push_back(e);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = addr(ch, r);
    @(posedge HCLK); #1;
    PENABLE = 1'b1;
    @(posedge HCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  // Sampled value reflects state after the first edge following the call.
  task automatic chk_irq(input logic [N-1:0] exp, input string name);
    exp_t e;
    @(posedge HCLK); #1;
    e.data = 32'(exp); e.err = 1'b0; e.name = name;
    q.push_back(e);
    irq_req = 1'b1;
    @(negedge HCLK); #1;
    irq_req = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    HRESETn = 1'b0;
    idle(2); #1;
    HRESETn = 1'b1;

    for (int c = 0; c < N; c++)
      for (int r = 0; r < 4; r++)
        apb_rd(c, r, 32'd0, 1'b0, "reset_reg");
    apb_rd(N, 0, 32'd0, 1'b1, "bad_channel_read");
    chk_irq(4'h0, "reset_irq");

    // Prescaler: ticks every 4 cycles, count frozen once EN drops.
    apb_wr(0, 1, 32'h0000_0301);
    idle(18);
    apb_rd(0, 0, 32'd5, 1'b0, "presc_count5");
    idle(1);
    apb_wr(0, 1, 32'd0);
    idle(10);
    apb_rd(0, 0, 32'd6, 1'b0, "presc_frozen");
    apb_rd(0, 1, 32'd0, 1'b0, "presc_ctrl_off");

    // Periodic compare on ch1 with period 11.
    apb_wr(1, 2, 32'd10);
    apb_wr(1, 1, 32'h9);
    chk_irq(4'h0, "cmp_irq_early");
    idle(8);
    chk_irq(4'h0, "cmp_irq_before");
    chk_irq(4'h2, "cmp_irq_rise");
    apb_rd(1, 0, 32'd2, 1'b0, "cmp_count_wrapped");
    apb_wr(1, 3, 32'h2);
    chk_irq(4'h0, "cmp_irq_cleared");
    idle(2);
    chk_irq(4'h0, "cmp_irq_before2");
    chk_irq(4'h2, "cmp_irq_second");
    idle(8);
    apb_wr(1, 3, 32'h2);
    apb_rd(1, 3, 32'h2, 1'b0, "w1c_vs_set");
    chk_irq(4'h2, "w1c_vs_set_irq");

    // COUNT write landing on a tick edge.
    apb_wr(1, 1, 32'h0000_0709);
    idle(5);
    apb_wr(1, 0, 32'd100);
    apb_rd(1, 0, 32'd100, 1'b0, "count_wr_on_tick");
    apb_wr(1, 1, 32'd0);
    apb_wr(1, 3, 32'h3);

    // One-shot on ch2.
    apb_wr(2, 2, 32'd4);
    apb_wr(2, 1, 32'hB);
    idle(50);
    apb_rd(2, 1, 32'hA, 1'b0, "oneshot_ctrl");
    apb_rd(2, 0, 32'd0, 1'b0, "oneshot_count");
    apb_rd(2, 3, 32'h2, 1'b0, "oneshot_status");
    chk_irq(4'h4, "oneshot_irq");
    apb_wr(2, 3, 32'h2);
    idle(50);
    apb_rd(2, 3, 32'h0, 1'b0, "oneshot_no_rearm");
    apb_rd(2, 0, 32'd0, 1'b0, "oneshot_count_hold");
    chk_irq(4'h0, "oneshot_irq_clear");

    // Overflow on ch0, PRESC=15, CMP=0.
    apb_wr(0, 0, 32'hFFFF_FFFE);
    apb_wr(0, 1, 32'h0000_0F05);
    idle(29);
    chk_irq(4'h0, "ovf_irq_before");
    apb_rd(0, 0, 32'd0, 1'b0, "ovf_count_zero");
    apb_rd(0, 3, 32'h1, 1'b0, "ovf_status_only");
    chk_irq(4'h1, "ovf_irq");

    // Channels 0 and 3 running concurrently.
    apb_wr(0, 1, 32'd0);
    apb_wr(0, 0, 32'd0);
    apb_wr(0, 1, 32'h0000_0201);
    apb_wr(3, 1, 32'h0000_0401);
    idle(40);
    apb_rd(0, 0, 32'd15, 1'b0, "indep_ch0");
    apb_rd(3, 0, 32'd9, 1'b0, "indep_ch3");
    chk_irq(4'h0, "indep_irq");

    // Mid-count reset.
    @(posedge HCLK); #1;
    HRESETn = 1'b0;
    @(posedge HCLK); #1;
    HRESETn = 1'b1;
    apb_rd(0, 0, 32'd0, 1'b0, "midreset_count");
    apb_rd(3, 1, 32'd0, 1'b0, "midreset_ctrl");
    apb_rd(0, 3, 32'd0, 1'b0, "midreset_status");
    chk_irq(4'h0, "midreset_irq");

    @(posedge HCLK); #1;
    done_req = 1'b1;
    @(negedge HCLK); #1;
    done_req = 1'b0;
    #10;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
